// File: rtl/hvgen_param.sv
// hvgen_param: parameterised raster timing generator.
// Produces pixel/line counters, registered blanking and sync strobes, blanked
// RGB pass-through, line/frame start pulses and a field toggle. Sync start
// positions can be shifted by HOFFS/VOFFS. The shift takes effect only at a
// frame boundary, so a frame never has a torn sync pattern.
//
// Handshake: there is no valid/ready pair here. CE is a plain qualifier and
// every register advances only on a PCLK edge with CE=1. iRGB is sampled on
// that same edge, for the pixel addressed by HPOS/VPOS.
module hvgen_param #(
  parameter int H_TOTAL      = 456,
  parameter int H_ACTIVE     = 336,
  parameter int H_SYNC_START = 360,
  parameter int H_SYNC_WIDTH = 24,
  parameter int V_TOTAL      = 262,
  parameter int V_ACTIVE     = 240,
  parameter int V_SYNC_START = 240,
  parameter int V_SYNC_WIDTH = 3,
  parameter int HOFFS_W      = 5,
  parameter int VOFFS_W      = 3,
  parameter int H_STEP       = 2,
  parameter int V_STEP       = 2,
  parameter int RGB_W        = 8,
  parameter bit SYNC_POL     = 1'b0,
  localparam int HW          = $clog2(H_TOTAL),
  localparam int VW          = $clog2(V_TOTAL)
) (
  input  logic               PCLK,
  input  logic               RESET_N,
  input  logic               CE,
  input  logic [HOFFS_W-1:0] HOFFS,
  input  logic [VOFFS_W-1:0] VOFFS,
  input  logic [RGB_W-1:0]   iRGB,
  output logic [HW-1:0]      HPOS,
  output logic [VW-1:0]      VPOS,
  output logic [RGB_W-1:0]   oRGB,
  output logic               HBLK,
  output logic               VBLK,
  output logic               HSYN,
  output logic               VSYN,
  output logic               LINE_ST,
  output logic               FRAME_ST,
  output logic               FIELD
);

  // Reject geometries that cannot produce a sensible raster.
  if (!(H_ACTIVE < H_TOTAL)) begin : g_bad_h_active
    $error("hvgen_param: H_ACTIVE must be below H_TOTAL");
  end
  if (!(V_ACTIVE < V_TOTAL)) begin : g_bad_v_active
    $error("hvgen_param: V_ACTIVE must be below V_TOTAL");
  end
  if (!(H_SYNC_WIDTH > 0 && H_SYNC_WIDTH < H_TOTAL)) begin : g_bad_h_sync
    $error("hvgen_param: H_SYNC_WIDTH must be in 1..H_TOTAL-1");
  end
  if (!(V_SYNC_WIDTH > 0 && V_SYNC_WIDTH < V_TOTAL)) begin : g_bad_v_sync
    $error("hvgen_param: V_SYNC_WIDTH must be in 1..V_TOTAL-1");
  end

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic          SYN_ON  = SYNC_POL;
  localparam logic          SYN_OFF = ~SYNC_POL;

  // State registers
  logic [HW-1:0]      hcnt_q, hcnt_d;
  logic [VW-1:0]      vcnt_q, vcnt_d;
  logic [HOFFS_W-1:0] hoffs_l_q, hoffs_l_d;
  logic [VOFFS_W-1:0] voffs_l_q, voffs_l_d;
  logic [RGB_W-1:0]   orgb_q, orgb_d;
  logic               hblk_q, hblk_d;
  logic               vblk_q, vblk_d;
  logic               hsyn_q, hsyn_d;
  logic               vsyn_q, vsyn_d;
  logic               line_st_q, line_st_d;
  logic               frame_st_q, frame_st_d;
  logic               field_q, field_d;

  // Decoded counter conditions
  logic h_last, v_last, h_zero, frame_zero, in_blank;

  // Sync window arithmetic, done at 32 bits so large offsets never truncate
  logic [31:0] hs_sum, hs_b, h_dist;
  logic [31:0] vs_sum, vs_b, v_dist;
  logic        h_sync_act, v_sync_act;

  // Decode counter positions used by several next-state terms.
  always_comb begin
    h_last     = (hcnt_q == H_LAST);
    v_last     = (vcnt_q == V_LAST);
    h_zero     = (hcnt_q == '0);
    frame_zero = h_zero && (vcnt_q == '0);
    in_blank   = (hcnt_q >= H_ACT) || (vcnt_q >= V_ACT);
  end

  // Horizontal sync window: distance from the shifted start, modulo the line.
  always_comb begin
    hs_sum = 32'(H_SYNC_START) + 32'(hoffs_l_q) * 32'(H_STEP);
    hs_b   = hs_sum % 32'(H_TOTAL);
    if (32'(hcnt_q) >= hs_b) begin
      h_dist = 32'(hcnt_q) - hs_b;
    end else begin
      h_dist = 32'(hcnt_q) + 32'(H_TOTAL) - hs_b;
    end
    h_sync_act = (h_dist < 32'(H_SYNC_WIDTH));
  end

  // Vertical sync window: same wrap-aware distance, in lines.
  always_comb begin
    vs_sum = 32'(V_SYNC_START) + 32'(voffs_l_q) * 32'(V_STEP);
    vs_b   = vs_sum % 32'(V_TOTAL);
    if (32'(vcnt_q) >= vs_b) begin
      v_dist = 32'(vcnt_q) - vs_b;
    end else begin
      v_dist = 32'(vcnt_q) + 32'(V_TOTAL) - vs_b;
    end
    v_sync_act = (v_dist < 32'(V_SYNC_WIDTH));
  end

  // Raster counters: pixel counter wraps per line, line counter per frame.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (CE) begin
      if (h_last) begin
        hcnt_d = '0;
        vcnt_d = v_last ? '0 : vcnt_q + VW'(1);
      end else begin
        hcnt_d = hcnt_q + HW'(1);
      end
    end
  end

  // Offset latches: the requested shift is sampled on the last pixel of a frame.
  always_comb begin
    hoffs_l_d = hoffs_l_q;
    voffs_l_d = voffs_l_q;
    if (CE && h_last && v_last) begin
      hoffs_l_d = HOFFS;
      voffs_l_d = VOFFS;
    end
  end

  // Pixel-path outputs: blanking flags and blanked colour, one CE behind counters.
  always_comb begin
    hblk_d = hblk_q;
    vblk_d = vblk_q;
    orgb_d = orgb_q;
    if (CE) begin
      hblk_d = (hcnt_q >= H_ACT);
      vblk_d = (vcnt_q >= V_ACT);
      orgb_d = in_blank ? '0 : iRGB;
    end
  end

  // Sync outputs: HSYN follows every CE, VSYN only updates at the start of a line.
  always_comb begin
    hsyn_d = hsyn_q;
    vsyn_d = vsyn_q;
    if (CE) begin
      hsyn_d = h_sync_act ? SYN_ON : SYN_OFF;
      if (h_zero) begin
        vsyn_d = v_sync_act ? SYN_ON : SYN_OFF;
      end
    end
  end

  // Start pulses and field flag; each pulse is held until the next CE.
  always_comb begin
    line_st_d  = line_st_q;
    frame_st_d = frame_st_q;
    field_d    = field_q;
    if (CE) begin
      line_st_d  = h_zero;
      frame_st_d = frame_zero;
      if (frame_zero) begin
        field_d = ~field_q;
      end
    end
  end

  // All state registers; asynchronous reset aborts the frame immediately.
  always_ff @(posedge PCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      hoffs_l_q  <= '0;
      voffs_l_q  <= '0;
      orgb_q     <= '0;
      hblk_q     <= 1'b1;
      vblk_q     <= 1'b1;
      hsyn_q     <= SYN_OFF;
      vsyn_q     <= SYN_OFF;
      line_st_q  <= 1'b0;
      frame_st_q <= 1'b0;
      field_q    <= 1'b0;
    end else begin
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      hoffs_l_q  <= hoffs_l_d;
      voffs_l_q  <= voffs_l_d;
      orgb_q     <= orgb_d;
      hblk_q     <= hblk_d;
      vblk_q     <= vblk_d;
      hsyn_q     <= hsyn_d;
      vsyn_q     <= vsyn_d;
      line_st_q  <= line_st_d;
      frame_st_q <= frame_st_d;
      field_q    <= field_d;
    end
  end

  // Counters are visible directly; everything else comes straight from flops.
  assign HPOS     = hcnt_q;
  assign VPOS     = vcnt_q;
  assign oRGB     = orgb_q;
  assign HBLK     = hblk_q;
  assign VBLK     = vblk_q;
  assign HSYN     = hsyn_q;
  assign VSYN     = vsyn_q;
  assign LINE_ST  = line_st_q;
  assign FRAME_ST = frame_st_q;
  assign FIELD    = field_q;

endmodule

// File: tb/tb_hvgen_param.sv
// tb_hvgen_param: directed bench for hvgen_param.
// Instance a: default geometry. Instance c: default geometry with the sync
// start moved near the end of the line, so the sync pulse wraps. Instance b:
// a small 20x10 raster with active-high sync, used for frame-level behaviour.
module tb_hvgen_param;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic ce;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] hoffs_a, hoffs_b;
  logic [2:0] voffs_a, voffs_b;
  logic [7:0] irgb;

  logic [8:0] a_hpos, a_vpos, c_hpos, c_vpos;
  logic [7:0] a_orgb, c_orgb, b_orgb;
  logic a_hblk, a_vblk, a_hsyn, a_vsyn, a_line_st, a_frame_st, a_field;
  logic c_hblk, c_vblk, c_hsyn, c_vsyn, c_line_st, c_frame_st, c_field;
  logic [4:0] b_hpos;
  logic [3:0] b_vpos;
  logic b_hblk, b_vblk, b_hsyn, b_vsyn, b_line_st, b_frame_st, b_field;

  hvgen_param u_a (
    .PCLK(clk), .RESET_N(rst_n), .CE(ce), .HOFFS(hoffs_a), .VOFFS(voffs_a),
    .iRGB(irgb), .HPOS(a_hpos), .VPOS(a_vpos), .oRGB(a_orgb), .HBLK(a_hblk),
    .VBLK(a_vblk), .HSYN(a_hsyn), .VSYN(a_vsyn), .LINE_ST(a_line_st),
    .FRAME_ST(a_frame_st), .FIELD(a_field)
  );

  hvgen_param #(.H_SYNC_START(440)) u_c (
    .PCLK(clk), .RESET_N(rst_n), .CE(ce), .HOFFS(hoffs_a), .VOFFS(voffs_a),
    .iRGB(irgb), .HPOS(c_hpos), .VPOS(c_vpos), .oRGB(c_orgb), .HBLK(c_hblk),
    .VBLK(c_vblk), .HSYN(c_hsyn), .VSYN(c_vsyn), .LINE_ST(c_line_st),
    .FRAME_ST(c_frame_st), .FIELD(c_field)
  );

  hvgen_param #(
    .H_TOTAL(20), .H_ACTIVE(12), .H_SYNC_START(14), .H_SYNC_WIDTH(4),
    .V_TOTAL(10), .V_ACTIVE(6), .V_SYNC_START(7), .V_SYNC_WIDTH(2),
    .SYNC_POL(1'b1)
  ) u_b (
    .PCLK(clk), .RESET_N(rst_n), .CE(ce), .HOFFS(hoffs_b), .VOFFS(voffs_b),
    .iRGB(irgb), .HPOS(b_hpos), .VPOS(b_vpos), .oRGB(b_orgb), .HBLK(b_hblk),
    .VBLK(b_vblk), .HSYN(b_hsyn), .VSYN(b_vsyn), .LINE_ST(b_line_st),
    .FRAME_ST(b_frame_st), .FIELD(b_field)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    ce    = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One 200-CE frame of instance b; new offsets are presented mid-frame.
  task automatic run_frame_b(input int fidx, input int exp_hs_first, input int exp_vs_first,
                             input logic exp_field, input logic [4:0] new_h, input logic [2:0] new_v);
    int hs_cnt, vs_cnt, hs_first, vs_first, rgb_cnt, ls_cnt, fs_cnt, hb_cnt, vb_cnt;
    hs_cnt = 0; vs_cnt = 0; hs_first = -1; vs_first = -1;
    rgb_cnt = 0; ls_cnt = 0; fs_cnt = 0; hb_cnt = 0; vb_cnt = 0;
    ce = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (i == 0) check($sformatf("f%0d_field", fidx), 32'(b_field), 32'(exp_field));
      if (b_hsyn) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = i;
      end
      if (b_vsyn) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = i;
      end
      if (b_orgb == 8'hA5) rgb_cnt++;
      if (b_line_st) ls_cnt++;
      if (b_frame_st) fs_cnt++;
      if (b_hblk) hb_cnt++;
      if (b_vblk) vb_cnt++;
      if (i == 50) begin
        hoffs_b = new_h;
        voffs_b = new_v;
      end
    end
    check($sformatf("f%0d_hs_cnt", fidx), 32'(hs_cnt), 32'd40);
    check($sformatf("f%0d_hs_first", fidx), 32'(hs_first), 32'(exp_hs_first));
    check($sformatf("f%0d_vs_cnt", fidx), 32'(vs_cnt), 32'd40);
    check($sformatf("f%0d_vs_first", fidx), 32'(vs_first), 32'(exp_vs_first));
    check($sformatf("f%0d_rgb_cnt", fidx), 32'(rgb_cnt), 32'd72);
    check($sformatf("f%0d_line_st_cnt", fidx), 32'(ls_cnt), 32'd10);
    check($sformatf("f%0d_frame_st_cnt", fidx), 32'(fs_cnt), 32'd1);
    check($sformatf("f%0d_hblk_cnt", fidx), 32'(hb_cnt), 32'd80);
    check($sformatf("f%0d_vblk_cnt", fidx), 32'(vb_cnt), 32'd80);
  endtask

  // ---------------- stimulus ----------------
  logic c_hs_at [0:455];

  initial begin : main
    int a_hs_cnt, a_hs_first, a_hs_last, a_hb_cnt, a5_cnt, nz_cnt, ls_cnt, c_hs_cnt;
    rst_n = 1'b1; ce = 1'b0; irgb = 8'hA5;
    hoffs_a = '0; voffs_a = '0; hoffs_b = '0; voffs_b = '0;
    #1 rst_n = 1'b0;
    #20;

    // Reset values
    check("rst_hpos", 32'(a_hpos), 32'd0);
    check("rst_vpos", 32'(a_vpos), 32'd0);
    check("rst_hblk", 32'(a_hblk), 32'd1);
    check("rst_vblk", 32'(a_vblk), 32'd1);
    check("rst_hsyn", 32'(a_hsyn), 32'd1);
    check("rst_vsyn", 32'(a_vsyn), 32'd1);
    check("rst_orgb", 32'(a_orgb), 32'd0);
    check("rst_line_st", 32'(a_line_st), 32'd0);
    check("rst_frame_st", 32'(a_frame_st), 32'd0);
    check("rst_field", 32'(a_field), 32'd0);
    check("rst_b_hsyn", 32'(b_hsyn), 32'd0);
    check("rst_b_vsyn", 32'(b_vsyn), 32'd0);

    // One full default line with CE=1
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ce = 1'b1;
    a_hs_cnt = 0; a_hs_first = -1; a_hs_last = -1; a_hb_cnt = 0;
    a5_cnt = 0; nz_cnt = 0; ls_cnt = 0; c_hs_cnt = 0;
    for (int k = 1; k <= 456; k++) begin
      tick();
      if (k == 1) begin
        check("t1_hpos", 32'(a_hpos), 32'd1);
        check("t1_line_st", 32'(a_line_st), 32'd1);
        check("t1_frame_st", 32'(a_frame_st), 32'd1);
        check("t1_field", 32'(a_field), 32'd1);
        check("t1_hblk", 32'(a_hblk), 32'd0);
        check("t1_vblk", 32'(a_vblk), 32'd0);
        check("t1_orgb", 32'(a_orgb), 32'hA5);
      end
      if (k == 2) check("t2_frame_st", 32'(a_frame_st), 32'd0);
      if (k == 101) begin
        check("rgb_pass_5a", 32'(a_orgb), 32'h5A);
        irgb = 8'hA5;
      end
      if (k == 401) begin
        check("rgb_blank_ff", 32'(a_orgb), 32'd0);
        irgb = 8'hA5;
      end
      if (!a_hsyn) begin
        a_hs_cnt++;
        if (a_hs_first < 0) a_hs_first = int'(a_hpos);
        a_hs_last = int'(a_hpos);
      end
      if (a_hblk) a_hb_cnt++;
      if (a_orgb == 8'hA5) a5_cnt++;
      if (a_orgb != 8'h00) nz_cnt++;
      if (a_line_st) ls_cnt++;
      if (!c_hsyn) c_hs_cnt++;
      c_hs_at[c_hpos] = c_hsyn;
      if (k == 100) irgb = 8'h5A;
      if (k == 400) irgb = 8'hFF;
    end
    check("line_hs_cnt", 32'(a_hs_cnt), 32'd24);
    check("line_hs_first", 32'(a_hs_first), 32'd361);
    check("line_hs_last", 32'(a_hs_last), 32'd384);
    check("line_hblk_cnt", 32'(a_hb_cnt), 32'd120);
    check("line_a5_cnt", 32'(a5_cnt), 32'd335);
    check("line_nz_cnt", 32'(nz_cnt), 32'd336);
    check("line_st_cnt", 32'(ls_cnt), 32'd1);
    check("line_end_hpos", 32'(a_hpos), 32'd0);
    check("line_end_vpos", 32'(a_vpos), 32'd1);
    check("wrap_hs_cnt", 32'(c_hs_cnt), 32'd24);
    check("wrap_hs_at0", 32'(c_hs_at[0]), 32'd0);
    check("wrap_hs_at8", 32'(c_hs_at[8]), 32'd0);
    check("wrap_hs_at9", 32'(c_hs_at[9]), 32'd1);
    check("wrap_hs_at440", 32'(c_hs_at[440]), 32'd1);
    check("wrap_hs_at441", 32'(c_hs_at[441]), 32'd0);

    // Small raster: offset latching at frame boundaries, sync wrap, counts
    hoffs_b = '0; voffs_b = '0;
    do_reset();
    run_frame_b(0, 14, 140, 1'b1, 5'd2, 3'd1);
    run_frame_b(1, 0, 0, 1'b0, 5'd31, 3'd7);
    run_frame_b(2, 16, 20, 1'b1, 5'd0, 3'd0);

    // CE active one cycle in three: all timing stretches by 3
    do_reset();
    a_hs_cnt = 0; ls_cnt = 0;
    for (int i = 0; i < 1368; i++) begin
      ce = (i % 3 == 0);
      tick();
      if (i == 1) check("ce3_hold_hpos", 32'(a_hpos), 32'd1);
      if (!a_hsyn) a_hs_cnt++;
      if (a_line_st) ls_cnt++;
    end
    check("ce3_hs_clocks", 32'(a_hs_cnt), 32'd72);
    check("ce3_line_st_clocks", 32'(ls_cnt), 32'd3);
    check("ce3_end_hpos", 32'(a_hpos), 32'd0);
    check("ce3_end_vpos", 32'(a_vpos), 32'd1);

    // Asynchronous reset in the middle of line 1
    do_reset();
    ce = 1'b1;
    for (int i = 0; i < 656; i++) tick();
    check("pre_rst_hpos", 32'(a_hpos), 32'd200);
    check("pre_rst_vpos", 32'(a_vpos), 32'd1);
    check("pre_rst_field", 32'(a_field), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_hpos", 32'(a_hpos), 32'd0);
    check("arst_vpos", 32'(a_vpos), 32'd0);
    check("arst_hblk", 32'(a_hblk), 32'd1);
    check("arst_vblk", 32'(a_vblk), 32'd1);
    check("arst_hsyn", 32'(a_hsyn), 32'd1);
    check("arst_orgb", 32'(a_orgb), 32'd0);
    check("arst_field", 32'(a_field), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("post_rst_hpos", 32'(a_hpos), 32'd1);
    check("post_rst_vpos", 32'(a_vpos), 32'd0);
    check("post_rst_frame_st", 32'(a_frame_st), 32'd1);

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hvgen_param.md
HVGEN_PARAM -- requirements
Module: hvgen_param

Interface
REQ-001 The block SHALL have parameter H_TOTAL, default 456, meaning pixels per line.
REQ-002 The block SHALL have parameter H_ACTIVE, default 336, meaning visible pixels per line.
REQ-003 The block SHALL have parameter H_SYNC_START, default 360, meaning base HSYNC start pixel.
REQ-004 The block SHALL have parameter H_SYNC_WIDTH, default 24, meaning HSYNC length in pixels.
REQ-005 The block SHALL have parameter V_TOTAL, default 262, meaning lines per frame.
REQ-006 The block SHALL have parameter V_ACTIVE, default 240, meaning visible lines per frame.
REQ-007 The block SHALL have parameter V_SYNC_START, default 240, meaning base VSYNC start line.
REQ-008 The block SHALL have parameter V_SYNC_WIDTH, default 3, meaning VSYNC length in lines.
REQ-009 The block SHALL have parameters HOFFS_W = 5 and VOFFS_W = 3, meaning offset input widths.
REQ-010 The block SHALL have parameters H_STEP = 2 and V_STEP = 2, meaning pixels/lines per offset unit.
REQ-011 The block SHALL have parameter RGB_W, default 8, meaning colour bus width.
REQ-012 The block SHALL have parameter SYNC_POL, default 0, meaning sync active level (0 = active-low).
REQ-013 The block SHALL have port PCLK, input, width 1, the sole clock.
REQ-014 The block SHALL have port RESET_N, input, width 1; reset is asynchronous and active-low.
REQ-015 The block SHALL have port CE, input, width 1, pixel enable; all state advances only on PCLK edges with CE=1.
REQ-016 The block SHALL have ports HOFFS [HOFFS_W] and VOFFS [VOFFS_W], inputs, unsigned sync shift requests.
REQ-017 The block SHALL have port iRGB [RGB_W], input, pixel data for the current HPOS/VPOS.
REQ-018 The block SHALL have ports HPOS and VPOS, outputs, each clog2 of its total wide, giving the current counter values.
REQ-019 The block SHALL have ports oRGB [RGB_W], HBLK, VBLK, HSYN, VSYN, outputs, all registered.
REQ-020 The block SHALL have ports LINE_ST and FRAME_ST, outputs, 1-CE pulses; and FIELD, output, toggling once per frame.

Function
REQ-021 hcnt SHALL count 0..H_TOTAL-1 and wrap to 0; vcnt SHALL increment only on an hcnt wrap and wrap V_TOTAL-1 -> 0.
REQ-022 HPOS and VPOS SHALL equal hcnt and vcnt combinationally.
REQ-023 On each CE: HBLK <= (hcnt >= H_ACTIVE); VBLK <= (vcnt >= V_ACTIVE); 1-CE latency from counters.
REQ-024 On each CE: oRGB <= 0 if (hcnt >= H_ACTIVE or vcnt >= V_ACTIVE), else iRGB, aligned with HBLK/VBLK.
REQ-025 Effective start HS_B SHALL be (H_SYNC_START + HOFFS_L*H_STEP) mod H_TOTAL, computed without truncation; VS_B likewise with V terms.
REQ-026 HSYN SHALL be active (level SYNC_POL) for exactly H_SYNC_WIDTH CEs starting the CE after hcnt==HS_B, wrapping across hcnt=0 when HS_B+H_SYNC_WIDTH > H_TOTAL.
REQ-027 VSYN SHALL be active for exactly V_SYNC_WIDTH lines, changing only on the CE where hcnt==0 (registered), wrapping across vcnt=0 like HSYN.
REQ-028 HOFFS_L/VOFFS_L SHALL latch HOFFS/VOFFS only on the CE with hcnt==H_TOTAL-1 and vcnt==V_TOTAL-1; mid-frame input changes SHALL NOT alter current-frame timing.
REQ-029 Line and frame geometry SHALL be constant; offsets SHALL move sync only, never active area or totals.
REQ-030 LINE_ST SHALL pulse for the CE following hcnt==0; FRAME_ST SHALL pulse for the CE following hcnt==0 and vcnt==0, FIELD toggling at that same edge.
REQ-031 With CE=0, all registers and outputs SHALL hold.
REQ-032 Parameters SHALL satisfy H_ACTIVE<H_TOTAL, V_ACTIVE<V_TOTAL, 0<H_SYNC_WIDTH<H_TOTAL, 0<V_SYNC_WIDTH<V_TOTAL; elaboration SHALL fail otherwise.

Reset
REQ-033 RESET_N=0 SHALL immediately force hcnt=0, vcnt=0, HOFFS_L=0, VOFFS_L=0, HBLK=1, VBLK=1, HSYN=VSYN=~SYNC_POL, oRGB=0, LINE_ST=FRAME_ST=0, FIELD=0.
REQ-034 Reset asserted mid-frame SHALL abort the frame; after release the first CE SHALL begin at hcnt=0, vcnt=0.

Verification
REQ-035 Defaults, CE=1, offsets 0: HSYN low for CEs after hcnt 360..383, period 456 CEs; VSYN low lines 240..242; frame = 119,472 CEs.
REQ-036 HOFFS=31 latched: HSYN starts after hcnt=422, lasts 24 CEs; HOFFS changed mid-frame -> no timing change until next frame.
REQ-037 H_SYNC_START=440, HOFFS=0: HSYN active hcnt 440..455 then 0..7 (24 CEs total across wrap).
REQ-038 iRGB=8'hA5 constant: oRGB=8'hA5 only while HBLK=0 and VBLK=0, 0 elsewhere; 336x240 non-zero pixels per frame.
REQ-039 CE toggling 1-of-3 cycles: all periods scale by 3, outputs hold during CE=0.
REQ-040 RESET_N pulsed low at hcnt=200, vcnt=100: outputs take reset values asynchronously, FIELD=0, counting restarts at 0,0.
